// File: rtl/axil_dp_ram_1clk.sv
// Dual-port AXI4-Lite RAM on a single clock: ports A and B share one word array.
// Each port accepts one write and one read per handshake and answers one cycle later.
module axil_dp_ram_1clk #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 17,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [ADDR_WIDTH-1:0] s_axil_a_awaddr,
  input  logic [2:0]            s_axil_a_awprot,
  input  logic                  s_axil_a_awvalid,
  output logic                  s_axil_a_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_a_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_a_wstrb,
  input  logic                  s_axil_a_wvalid,
  output logic                  s_axil_a_wready,
  output logic [1:0]            s_axil_a_bresp,
  output logic                  s_axil_a_bvalid,
  input  logic                  s_axil_a_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_a_araddr,
  input  logic [2:0]            s_axil_a_arprot,
  input  logic                  s_axil_a_arvalid,
  output logic                  s_axil_a_arready,
  output logic [DATA_WIDTH-1:0] s_axil_a_rdata,
  output logic [1:0]            s_axil_a_rresp,
  output logic                  s_axil_a_rvalid,
  input  logic                  s_axil_a_rready,

  input  logic [ADDR_WIDTH-1:0] s_axil_b_awaddr,
  input  logic [2:0]            s_axil_b_awprot,
  input  logic                  s_axil_b_awvalid,
  output logic                  s_axil_b_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_b_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_b_wstrb,
  input  logic                  s_axil_b_wvalid,
  output logic                  s_axil_b_wready,
  output logic [1:0]            s_axil_b_bresp,
  output logic                  s_axil_b_bvalid,
  input  logic                  s_axil_b_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_b_araddr,
  input  logic [2:0]            s_axil_b_arprot,
  input  logic                  s_axil_b_arvalid,
  output logic                  s_axil_b_arready,
  output logic [DATA_WIDTH-1:0] s_axil_b_rdata,
  output logic [1:0]            s_axil_b_rresp,
  output logic                  s_axil_b_rvalid,
  input  logic                  s_axil_b_rready
);

  localparam int OFFS_W = $clog2(STRB_WIDTH);
  localparam int WORD_W = ADDR_WIDTH - OFFS_W;
  localparam int DEPTH  = 2 ** WORD_W;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Index 0 is port A, index 1 is port B
  logic [1:0]            awvalid, wvalid, bready, arvalid, rready;
  logic [WORD_W-1:0]     wr_word [2];
  logic [WORD_W-1:0]     rd_word [2];
  logic [DATA_WIDTH-1:0] wdata   [2];
  logic [STRB_WIDTH-1:0] wstrb   [2];

  logic [1:0]            awready_p1, bvalid_p1, arready_p1, rvalid_p1;
  logic [DATA_WIDTH-1:0] rdata_p1 [2];
  logic [1:0]            wr_en, rd_en;

  assign awvalid    = {s_axil_b_awvalid, s_axil_a_awvalid};
  assign wvalid     = {s_axil_b_wvalid,  s_axil_a_wvalid};
  assign bready     = {s_axil_b_bready,  s_axil_a_bready};
  assign arvalid    = {s_axil_b_arvalid, s_axil_a_arvalid};
  assign rready     = {s_axil_b_rready,  s_axil_a_rready};
  assign wr_word[0] = s_axil_a_awaddr[ADDR_WIDTH-1:OFFS_W];
  assign wr_word[1] = s_axil_b_awaddr[ADDR_WIDTH-1:OFFS_W];
  assign rd_word[0] = s_axil_a_araddr[ADDR_WIDTH-1:OFFS_W];
  assign rd_word[1] = s_axil_b_araddr[ADDR_WIDTH-1:OFFS_W];
  assign wdata[0]   = s_axil_a_wdata;
  assign wdata[1]   = s_axil_b_wdata;
  assign wstrb[0]   = s_axil_a_wstrb;
  assign wstrb[1]   = s_axil_b_wstrb;

  logic unused_ok;
  assign unused_ok = ^{s_axil_a_awprot, s_axil_a_arprot, s_axil_b_awprot, s_axil_b_arprot,
                       s_axil_a_awaddr[OFFS_W-1:0], s_axil_a_araddr[OFFS_W-1:0],
                       s_axil_b_awaddr[OFFS_W-1:0], s_axil_b_araddr[OFFS_W-1:0]};

  // Accept decisions: AW and W only together, never while a response is stuck
  always_comb begin
    wr_en = '0;
    rd_en = '0;
    for (int p = 0; p < 2; p++) begin
      wr_en[p] = !rst && awvalid[p] && wvalid[p] && !awready_p1[p] && (!bvalid_p1[p] || bready[p]);
      rd_en[p] = !rst && arvalid[p] && !arready_p1[p] && (!rvalid_p1[p] || rready[p]);
    end
  end

  // Stage p0 -> p1: handshake and response-valid registers
  always_ff @(posedge clk) begin
    if (rst) begin
      awready_p1 <= '0;
      bvalid_p1  <= '0;
      arready_p1 <= '0;
      rvalid_p1  <= '0;
    end else begin
      awready_p1 <= wr_en;
      arready_p1 <= rd_en;
      for (int p = 0; p < 2; p++) begin
        if (wr_en[p])      bvalid_p1[p] <= 1'b1;
        else if (bready[p]) bvalid_p1[p] <= 1'b0;
        if (rd_en[p])      rvalid_p1[p] <= 1'b1;
        else if (rready[p]) rvalid_p1[p] <= 1'b0;
      end
    end
  end

  // Reads sample the array before this edge's writes land (read-before-write)
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_p1[0] <= '0;
      rdata_p1[1] <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (rd_en[p]) rdata_p1[p] <= mem[rd_word[p]];
      end
    end
  end

  // Port B is applied first so port A's bytes override it on a same-word collision
  always_ff @(posedge clk) begin
    for (int p = 1; p >= 0; p--) begin
      if (wr_en[p]) begin
        for (int i = 0; i < STRB_WIDTH; i++) begin
          if (wstrb[p][i]) mem[wr_word[p]][8*i +: 8] <= wdata[p][8*i +: 8];
        end
      end
    end
  end

  assign s_axil_a_awready = awready_p1[0];
  assign s_axil_a_wready  = awready_p1[0];
  assign s_axil_a_bresp   = 2'b00;
  assign s_axil_a_bvalid  = bvalid_p1[0];
  assign s_axil_a_arready = arready_p1[0];
  assign s_axil_a_rdata   = rdata_p1[0];
  assign s_axil_a_rresp   = 2'b00;
  assign s_axil_a_rvalid  = rvalid_p1[0];

  assign s_axil_b_awready = awready_p1[1];
  assign s_axil_b_wready  = awready_p1[1];
  assign s_axil_b_bresp   = 2'b00;
  assign s_axil_b_bvalid  = bvalid_p1[1];
  assign s_axil_b_arready = arready_p1[1];
  assign s_axil_b_rdata   = rdata_p1[1];
  assign s_axil_b_rresp   = 2'b00;
  assign s_axil_b_rvalid  = rvalid_p1[1];

endmodule

// File: tb/tb_axil_dp_ram_1clk.sv
// Bench for axil_dp_ram_1clk: directed cases plus randomized traffic on both ports,
// checked by a scoreboard fed from a word-array reference model.
module tb_axil_dp_ram_1clk;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [16:0] awaddr [2];
  logic [16:0] araddr [2];
  logic [31:0] wdata  [2];
  logic [3:0]  wstrb  [2];
  logic [1:0]  awvalid, wvalid, bready, arvalid, rready;

  logic        awready_o [2];
  logic        wready_o  [2];
  logic        bvalid_o  [2];
  logic        arready_o [2];
  logic        rvalid_o  [2];
  logic [1:0]  bresp_o   [2];
  logic [1:0]  rresp_o   [2];
  logic [31:0] rdata_o   [2];

  int errors = 0;
  int checks = 0;

  logic [31:0] mdl [32768];
  logic [31:0] rq0 [$];
  logic [31:0] rq1 [$];
  logic [1:0]  bq0 [$];
  logic [1:0]  bq1 [$];

  always #5 clk = ~clk;

  axil_dp_ram_1clk dut (
    .clk(clk), .rst(rst),
    .s_axil_a_awaddr(awaddr[0]), .s_axil_a_awprot(3'b000), .s_axil_a_awvalid(awvalid[0]),
    .s_axil_a_awready(awready_o[0]), .s_axil_a_wdata(wdata[0]), .s_axil_a_wstrb(wstrb[0]),
    .s_axil_a_wvalid(wvalid[0]), .s_axil_a_wready(wready_o[0]), .s_axil_a_bresp(bresp_o[0]),
    .s_axil_a_bvalid(bvalid_o[0]), .s_axil_a_bready(bready[0]), .s_axil_a_araddr(araddr[0]),
    .s_axil_a_arprot(3'b000), .s_axil_a_arvalid(arvalid[0]), .s_axil_a_arready(arready_o[0]),
    .s_axil_a_rdata(rdata_o[0]), .s_axil_a_rresp(rresp_o[0]), .s_axil_a_rvalid(rvalid_o[0]),
    .s_axil_a_rready(rready[0]),
    .s_axil_b_awaddr(awaddr[1]), .s_axil_b_awprot(3'b000), .s_axil_b_awvalid(awvalid[1]),
    .s_axil_b_awready(awready_o[1]), .s_axil_b_wdata(wdata[1]), .s_axil_b_wstrb(wstrb[1]),
    .s_axil_b_wvalid(wvalid[1]), .s_axil_b_wready(wready_o[1]), .s_axil_b_bresp(bresp_o[1]),
    .s_axil_b_bvalid(bvalid_o[1]), .s_axil_b_bready(bready[1]), .s_axil_b_araddr(araddr[1]),
    .s_axil_b_arprot(3'b000), .s_axil_b_arvalid(arvalid[1]), .s_axil_b_arready(arready_o[1]),
    .s_axil_b_rdata(rdata_o[1]), .s_axil_b_rresp(rresp_o[1]), .s_axil_b_rvalid(rvalid_o[1]),
    .s_axil_b_rready(rready[1])
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model and scoreboard: reads see the array before same-cycle writes,
  // port B writes land before port A so A wins per byte.
  always @(negedge clk) begin
    if (!rst) begin
      if (arready_o[0]) rq0.push_back(mdl[araddr[0][16:2]]);
      if (arready_o[1]) rq1.push_back(mdl[araddr[1][16:2]]);
      for (int p = 1; p >= 0; p--) begin
        if (awready_o[p]) begin
          chk($sformatf("wready_with_awready_%0d", p), 64'(wready_o[p]), 64'd1);
          for (int i = 0; i < 4; i++)
            if (wstrb[p][i]) mdl[awaddr[p][16:2]][8*i +: 8] = wdata[p][8*i +: 8];
          if (p == 0) bq0.push_back(2'b00);
          else        bq1.push_back(2'b00);
        end
      end
      if (bvalid_o[0] && bready[0]) begin
        if (bq0.size() == 0) chk("bvalid_a_unexpected", 64'd1, 64'd0);
        else chk("bresp_a", 64'(bresp_o[0]), 64'(bq0.pop_front()));
      end
      if (bvalid_o[1] && bready[1]) begin
        if (bq1.size() == 0) chk("bvalid_b_unexpected", 64'd1, 64'd0);
        else chk("bresp_b", 64'(bresp_o[1]), 64'(bq1.pop_front()));
      end
      if (rvalid_o[0] && rready[0]) begin
        if (rq0.size() == 0) chk("rvalid_a_unexpected", 64'd1, 64'd0);
        else begin
          chk("rdata_a", 64'(rdata_o[0]), 64'(rq0.pop_front()));
          chk("rresp_a", 64'(rresp_o[0]), 64'd0);
        end
      end
      if (rvalid_o[1] && rready[1]) begin
        if (rq1.size() == 0) chk("rvalid_b_unexpected", 64'd1, 64'd0);
        else begin
          chk("rdata_b", 64'(rdata_o[1]), 64'(rq1.pop_front()));
          chk("rresp_b", 64'(rresp_o[1]), 64'd0);
        end
      end
    end
  end

  task automatic do_write(input int p, input logic [16:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    awaddr[p] = a; wdata[p] = d; wstrb[p] = s;
    awvalid[p] = 1'b1; wvalid[p] = 1'b1;
    @(negedge clk);
    while (!awready_o[p]) begin
      if (++n > 100) begin
        chk($sformatf("aw_timeout_%0d", p), 64'd0, 64'd1);
        awvalid[p] = 1'b0; wvalid[p] = 1'b0;
        return;
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    awvalid[p] = 1'b0; wvalid[p] = 1'b0;
  endtask

  task automatic do_read(input int p, input logic [16:0] a, output logic [31:0] d);
    int n = 0;
    d = '0;
    araddr[p] = a; arvalid[p] = 1'b1;
    @(negedge clk);
    while (!arready_o[p]) begin
      if (++n > 100) begin
        chk($sformatf("ar_timeout_%0d", p), 64'd0, 64'd1);
        arvalid[p] = 1'b0;
        return;
      end
      @(negedge clk);
    end
    n = 0;
    while (1) begin
      if (rvalid_o[p] && rready[p]) begin
        d = rdata_o[p];
        break;
      end
      @(posedge clk); #1 arvalid[p] = 1'b0;
      @(negedge clk);
      if (++n > 100) begin
        chk($sformatf("r_timeout_%0d", p), 64'd0, 64'd1);
        return;
      end
    end
    @(posedge clk); #1 arvalid[p] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rnd_writes(input int p, input int n);
    for (int k = 0; k < n; k++) begin
      do_write(p, 17'($urandom_range(0, 63)), $urandom, 4'($urandom));
      idle($urandom_range(0, 2));
    end
  endtask

  task automatic rnd_reads(input int p, input int n);
    logic [31:0] d;
    for (int k = 0; k < n; k++) begin
      do_read(p, 17'($urandom_range(0, 63)), d);
      idle($urandom_range(0, 2));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    bit stop;
    for (int i = 0; i < 32768; i++) mdl[i] = '0;
    for (int p = 0; p < 2; p++) begin
      awaddr[p] = 17'h40; araddr[p] = 17'h40; wdata[p] = 32'hFFFF_FFFF; wstrb[p] = 4'hF;
    end
    awvalid = 2'b11; wvalid = 2'b11; arvalid = 2'b11; bready = 2'b11; rready = 2'b11;

    // Reset with every valid high: nothing may be accepted
    @(posedge clk);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++)
        chk($sformatf("reset_outputs_%0d", p),
            64'({awready_o[p], wready_o[p], arready_o[p], bvalid_o[p], rvalid_o[p],
                 bresp_o[p], rresp_o[p], rdata_o[p]}), 64'd0);
    end
    awvalid = 2'b00; wvalid = 2'b00; arvalid = 2'b00;
    @(posedge clk); #1 rst = 1'b0;
    idle(2);

    // Preload the random-traffic window so every word has a known value
    for (int w = 0; w < 16; w++) do_write(0, 17'(w * 4), $urandom, 4'hF);
    idle(3);

    do_write(1, 17'h100, 32'hDEAD_BEEF, 4'hF);
    do_read(0, 17'h100, d);
    chk("b_write_a_read", 64'(d), 64'hDEAD_BEEF);

    do_write(0, 17'h8, 32'h1122_3344, 4'hF);
    do_write(0, 17'h8, 32'hAABB_CCDD, 4'b0101);
    do_read(1, 17'h8, d);
    chk("strobe_merge", 64'(d), 64'h11BB_33DD);

    // Backpressure: response stalls and blocks the next write
    bready[1] = 1'b0;
    do_write(1, 17'h30, 32'h0000_00AA, 4'hF);
    fork
      do_write(1, 17'h34, 32'h0000_00BB, 4'hF);
      begin
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          chk("bp_bvalid_held", 64'(bvalid_o[1]), 64'd1);
          chk("bp_no_accept", 64'(awready_o[1]), 64'd0);
        end
        bready[1] = 1'b1;
      end
    join
    do_read(0, 17'h34, d);
    chk("bp_second_write", 64'(d), 64'h0000_00BB);

    // Same-word collision: A wins, concurrent read sees the old word
    do_write(1, 17'h20, 32'h0000_0055, 4'hF);
    idle(4);
    fork
      do_write(0, 17'h20, 32'h0000_0001, 4'hF);
      do_write(1, 17'h20, 32'h0000_0002, 4'hF);
      do_read(0, 17'h20, d);
    join
    chk("collision_read_old", 64'(d), 64'h0000_0055);
    idle(2);
    do_read(1, 17'h20, d);
    chk("collision_a_wins", 64'(d), 64'h0000_0001);

    do_write(0, 17'h1FFFC, 32'hCAFE_F00D, 4'hF);
    do_read(1, 17'h1FFFC, d);
    chk("top_word", 64'(d), 64'hCAFE_F00D);
    do_read(0, 17'h1FFFD, d);
    chk("top_word_alias", 64'(d), 64'hCAFE_F00D);

    // Randomized traffic on all four channels with random response stalls
    stop = 1'b0;
    fork
      begin
        fork
          rnd_writes(0, 60);
          rnd_writes(1, 60);
          rnd_reads(0, 60);
          rnd_reads(1, 60);
        join
        stop = 1'b1;
      end
      begin
        while (!stop) begin
          @(posedge clk); #1;
          bready = 2'($urandom); bready |= 2'($urandom);
          rready = 2'($urandom); rready |= 2'($urandom);
        end
      end
    join
    bready = 2'b11; rready = 2'b11;
    idle(10);

    chk("rq_a_drained", 64'(rq0.size()), 64'd0);
    chk("rq_b_drained", 64'(rq1.size()), 64'd0);
    chk("bq_a_drained", 64'(bq0.size()), 64'd0);
    chk("bq_b_drained", 64'(bq1.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
